// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types for the IF/LS memory port arbiter
package arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
  typedef enum logic {OWN_IF, OWN_LS} arb_owner_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// rtl/arb_starve_ctr.sv - saturating count of LS wins over a waiting IF
module arb_starve_ctr #(
  parameter int MAX = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);

  localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [W-1:0] r_cnt;
  logic         w_at_max;

  assign w_at_max = (r_cnt == W'(MAX));
  assign o_at_max = w_at_max;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_at_max) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_if,
  output logic              stall_ls,
  output logic              proto_err
);

  arb_state_t r_state;
  arb_owner_t r_owner;

  logic w_at_max;
  logic w_if_pri;
  logic w_ls_pri;
  logic w_grant_if;
  logic w_grant_ls;
  logic w_idle;

  assign w_idle = (r_state == ARB_IDLE);

  // Priority is resolved on the raw request lines, so a requester sitting in its
  // valid cycle keeps its turn; its grant is merely deferred by one cycle.
  assign w_if_pri   = if_req & (~ls_req | w_at_max);
  assign w_ls_pri   = ls_req & ~w_if_pri;
  assign w_grant_if = w_idle & w_if_pri & ~if_valid;
  assign w_grant_ls = w_idle & w_ls_pri & ~ls_valid;

  assign stall_if = if_req & ~if_valid;
  assign stall_ls = ls_req & ~ls_valid;

  arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .i_clk    (clk),
    .i_rst_n  (rst),
    .i_inc    (w_grant_ls & if_req),
    .i_clr    (w_grant_if),
    .o_at_max (w_at_max)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ARB_IDLE;
      r_owner   <= OWN_IF;
      if_gnt    <= 1'b0;
      ls_gnt    <= 1'b0;
      if_valid  <= 1'b0;
      ls_valid  <= 1'b0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      proto_err <= 1'b0;
    end else begin
      if_gnt   <= w_grant_if;
      ls_gnt   <= w_grant_ls;
      if_valid <= 1'b0;
      ls_valid <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (mem_ack) begin
            proto_err <= 1'b1;
          end
          if (w_grant_if) begin
            r_state   <= ARB_BUSY;
            r_owner   <= OWN_IF;
            mem_en    <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
          end else if (w_grant_ls) begin
            r_state   <= ARB_BUSY;
            r_owner   <= OWN_LS;
            mem_en    <= 1'b1;
            mem_we    <= ls_we;
            mem_addr  <= ls_addr;
            mem_wdata <= ls_wdata;
          end
        end
        ARB_BUSY: begin
          if (mem_ack) begin
            r_state <= ARB_IDLE;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            if (r_owner == OWN_LS) begin
              ls_rdata <= mem_rdata;
              ls_valid <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_valid <= 1'b1;
            end
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed checks for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic        if_gnt;
  logic [15:0] if_rdata;
  logic        if_valid;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [15:0] ls_addr = '0;
  logic [15:0] ls_wdata = '0;
  logic        ls_gnt;
  logic [15:0] ls_rdata;
  logic        ls_valid;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        stall_if;
  logic        stall_ls;
  logic        proto_err;

  int tests = 0;
  int errors = 0;
  logic [15:0] last_if_rd;
  logic [15:0] last_ls_rd;

  typedef struct {
    logic        is_ls;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          lat;
    logic [15:0] rdata;
    logic        exp_we;
  } vec_t;

  vec_t vecs[5];

  mem_port_arbiter #(
    .ADDR_W(16), .DATA_W(16), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata), .if_valid(if_valid),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rdata(ls_rdata), .ls_valid(ls_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_ls(stall_ls), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    if (v.is_ls) begin
      ls_req = 1'b1; ls_we = v.we; ls_addr = v.addr; ls_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr; ls_we = v.we;
    end
    @(negedge clk);
    check("gnt", v.is_ls ? ls_gnt : if_gnt, 1);
    check("mem_en", mem_en, 1);
    check("mem_we", mem_we, v.exp_we);
    check("mem_addr", mem_addr, v.addr);
    if (v.is_ls && v.we) check("mem_wdata", mem_wdata, v.wdata);
    check("stall_busy", v.is_ls ? stall_ls : stall_if, 1);
    for (int k = 0; k < v.lat; k++) begin
      @(negedge clk);
      check("mem_en_hold", mem_en, 1);
      check("mem_addr_hold", mem_addr, v.addr);
      if (k == 0) check("gnt_pulse", v.is_ls ? ls_gnt : if_gnt, 0);
    end
    mem_ack = 1'b1;
    mem_rdata = v.rdata;
    @(negedge clk);
    mem_ack = 1'b0;
    mem_rdata = '0;
    check("valid", v.is_ls ? ls_valid : if_valid, 1);
    check("rdata", v.is_ls ? ls_rdata : if_rdata, v.rdata);
    check("mem_en_drop", mem_en, 0);
    check("stall_done", v.is_ls ? stall_ls : stall_if, 0);
    check("other_rdata", v.is_ls ? if_rdata : ls_rdata, v.is_ls ? last_if_rd : last_ls_rd);
    if (v.is_ls) last_ls_rd = v.rdata; else last_if_rd = v.rdata;
    ls_req = 1'b0; if_req = 1'b0; ls_we = 1'b0;
    @(negedge clk);
    check("valid_pulse", v.is_ls ? ls_valid : if_valid, 0);
  endtask

  initial begin
    logic exp_ls [10];
    int n;
    int cyc;
    int last_v;
    int nvalid;

    vecs[0] = '{is_ls: 1'b1, we: 1'b0, addr: 16'h0020, wdata: 16'h0000, lat: 3, rdata: 16'hBEEF, exp_we: 1'b0};
    vecs[1] = '{is_ls: 1'b1, we: 1'b1, addr: 16'h0030, wdata: 16'h1234, lat: 0, rdata: 16'h0000, exp_we: 1'b1};
    vecs[2] = '{is_ls: 1'b0, we: 1'b0, addr: 16'h0040, wdata: 16'h0000, lat: 1, rdata: 16'hCAFE, exp_we: 1'b0};
    vecs[3] = '{is_ls: 1'b0, we: 1'b1, addr: 16'h0050, wdata: 16'h9999, lat: 2, rdata: 16'h1357, exp_we: 1'b0};
    vecs[4] = '{is_ls: 1'b1, we: 1'b0, addr: 16'hFFFF, wdata: 16'h0000, lat: 0, rdata: 16'hA5A5, exp_we: 1'b0};
    exp_ls = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    @(negedge clk);
    check("rst_mem_en", mem_en, 0);
    check("rst_gnt", {if_gnt, ls_gnt}, 0);
    check("rst_valid", {if_valid, ls_valid}, 0);
    check("rst_rdata", {if_rdata, ls_rdata}, 0);
    check("rst_mem_bus", {mem_we, mem_addr, mem_wdata}, 0);
    check("rst_proto", proto_err, 0);
    rst = 1'b1;

    // abandoned access: async drop of mem_en, then a clean re-grant
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0010;
    @(negedge clk);
    check("mid_gnt", ls_gnt, 1);
    check("mid_mem_en", mem_en, 1);
    #2 rst = 1'b0;
    #1 check("mid_async_drop", mem_en, 0);
    @(negedge clk);
    check("mid_no_valid", ls_valid, 0);
    check("mid_proto", proto_err, 0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_regrant", ls_gnt, 1);
    check("mid_regrant_addr", mem_addr, 16'h0010);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("mid_valid", ls_valid, 1);
    ls_req = 1'b0;
    @(negedge clk);

    last_if_rd = 16'h0000;
    last_ls_rd = 16'h0000;
    foreach (vecs[i]) run_vec(vecs[i]);

    // masking: a held if_req yields one grant per completion, never in the valid cycle
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0300;
    n = 0; cyc = 0; last_v = -1; nvalid = 0;
    while (n < 3 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      mem_ack = mem_en;
      if (if_valid) begin
        check("mask_no_gnt_in_valid", if_gnt, 0);
        last_v = cyc;
        nvalid++;
      end
      if (if_gnt) begin
        n++;
        if (last_v >= 0) check("mask_regrant_gap", cyc - last_v, 2);
      end
    end
    check("mask_grants", n, 3);
    check("mask_valids", nvalid, 2);
    @(negedge clk);
    mem_ack = 1'b0;
    check("mask_last_valid", if_valid, 1);
    if_req = 1'b0;
    @(negedge clk);

    // contention with starvation guard
    do_reset();
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0200;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0100;
    n = 0; cyc = 0;
    while (n < 10 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      mem_ack = mem_en;
      if (ls_gnt || if_gnt) begin
        check("cont_single_gnt", {ls_gnt, if_gnt} == 2'b11, 0);
        check("cont_order", ls_gnt, exp_ls[n]);
        n++;
      end
    end
    check("cont_grants", n, 10);
    @(negedge clk);
    mem_ack = 1'b0;
    if_req = 1'b0; ls_req = 1'b0;
    repeat (2) @(negedge clk);

    // ack while idle
    check("proto_pre", proto_err, 0);
    mem_ack = 1'b1;
    mem_rdata = 16'hDEAD;
    @(negedge clk);
    mem_ack = 1'b0;
    mem_rdata = '0;
    check("proto_set", proto_err, 1);
    check("proto_no_valid", {if_valid, ls_valid}, 0);
    repeat (3) @(negedge clk);
    check("proto_sticky", proto_err, 1);
    check("proto_no_valid_late", {if_valid, ls_valid}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
